fclass_sched: RTL and testbench

Pipelined, arbitrated front end for the shared single-precision classifier unit. It accepts FCLASS operands from NREQ requesters (integer issue ports), picks one per cycle by round-robin, and classifies it on a single `fclassifier` instance. The 10-bit class mask is returned zero-extended to XLEN, tagged with requester index and a caller tag. Full throughput with backpressure; sits between issue and the integer writeback arbiter.

---
 rtl/fclass_sched_pkg.sv | 32 +++
 rtl/fclass_rr_arb.sv | 45 ++++
 rtl/fclassifier.sv | 42 ++++
 rtl/fclass_sched.sv | 129 ++++++++++++
 tb/tb_fclass_sched.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fclass_sched_pkg.sv
// Shared widths and class-mask bit positions for the FCLASS front end.
// Consumers index the mask through FCLASS_* so bit order lives in one place.
package fclass_sched_pkg;

    localparam int EXPWIDTH = 8;
    localparam int SIGWIDTH = 24;
    localparam int XLEN     = 32;
    localparam int FLEN     = EXPWIDTH + SIGWIDTH;
    localparam int FCLASS_W = 10;

    localparam int FCLASS_NINF  = 9;
    localparam int FCLASS_NNORM = 8;
    localparam int FCLASS_NSUB  = 7;
    localparam int FCLASS_NZERO = 6;
    localparam int FCLASS_PZERO = 5;
    localparam int FCLASS_PSUB  = 4;
    localparam int FCLASS_PNORM = 3;
    localparam int FCLASS_PINF  = 2;
    localparam int FCLASS_SNAN  = 1;
    localparam int FCLASS_QNAN  = 0;

    typedef struct packed {
        logic                sign;
        logic [EXPWIDTH-1:0] exp;
        logic [SIGWIDTH-2:0] frac;
    } fp_t;

    function automatic logic [FCLASS_W-1:0] fclass_bit(input int idx);
        return {{(FCLASS_W-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/fclass_rr_arb.sv
// Round-robin arbiter: scans requests upward from rr_ptr, one-hot grant.
// Latency: grant is combinational from req; pointer updates on adv.
// Backpressure: pointer holds unless adv confirms the grant was taken.
module fclass_rr_arb #(
    parameter  int NREQ  = 2,
    localparam int PTR_W = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            adv,
    output logic [NREQ-1:0] grant
);

    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] gnt_idx;
    logic [PTR_W-1:0] ptr_nxt;
    logic             found;

    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        found   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (int'(rr_ptr) + k) % NREQ;
            if (!found && req[idx]) begin
                found   = 1'b1;
                gnt_idx = PTR_W'(idx);
                grant   = {{(NREQ-1){1'b0}}, 1'b1} << idx;
            end
        end
    end

    // Pointer moves to just past the winner so it becomes lowest priority.
    assign ptr_nxt = (gnt_idx == PTR_W'(NREQ-1)) ? '0 : gnt_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (rst)
            rr_ptr <= '0;
        else if (adv)
            rr_ptr <= ptr_nxt;
    end

endmodule

// File: rtl/fclassifier.sv
// Single-precision classifier producing a one-hot 10-bit class mask.
// Latency: combinational, no state.
// Backpressure: none; caller registers the result.
module fclassifier
    import fclass_sched_pkg::*;
(
    input  logic [FLEN-1:0]     operand,
    output logic [FCLASS_W-1:0] mask
);

    fp_t  f;
    logic exp_max;
    logic exp_zero;
    logic frac_zero;
    logic quiet;

    assign f         = operand;
    assign exp_max   = &f.exp;
    assign exp_zero  = ~|f.exp;
    assign frac_zero = ~|f.frac;
    assign quiet     = f.frac[SIGWIDTH-2];

    always_comb begin
        mask = '0;
        if (exp_max) begin
            if (frac_zero)
                mask = fclass_bit(f.sign ? FCLASS_NINF : FCLASS_PINF);
            else if (quiet)
                mask = fclass_bit(FCLASS_QNAN);
            else
                mask = fclass_bit(FCLASS_SNAN);
        end else if (exp_zero) begin
            if (frac_zero)
                mask = fclass_bit(f.sign ? FCLASS_NZERO : FCLASS_PZERO);
            else
                mask = fclass_bit(f.sign ? FCLASS_NSUB : FCLASS_PSUB);
        end else begin
            mask = fclass_bit(f.sign ? FCLASS_NNORM : FCLASS_PNORM);
        end
    end

endmodule

// File: rtl/fclass_sched.sv
// Arbitrated 2-stage FCLASS front end; optional sNaN counter under FCLASS_SNAN_CNT_EN.
// Latency: accept at edge N -> resp_valid in cycle N+2; one result per cycle.
// Backpressure: resp_ready low holds S2; S1 then fills and req_ready drops to zero.
module fclass_sched
    import fclass_sched_pkg::*;
#(
    parameter  int NREQ  = 2,
    parameter  int TAG_W = 5,
    localparam int SRC_W = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*FLEN-1:0]  req_data,
    input  logic [NREQ*TAG_W-1:0] req_tag,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [XLEN-1:0]       resp_data,
    output logic [TAG_W-1:0]      resp_tag,
    output logic [SRC_W-1:0]      resp_src
`ifdef FCLASS_SNAN_CNT_EN
    ,
    output logic [15:0]           snan_cnt
`endif
);

    logic                s1_v;
    logic [FLEN-1:0]     s1_dat;
    logic [TAG_W-1:0]    s1_tag;
    logic [SRC_W-1:0]    s1_src;

    logic                s2_v;
    logic [FCLASS_W-1:0] s2_mask;
    logic [TAG_W-1:0]    s2_tag;
    logic [SRC_W-1:0]    s2_src;

    logic                s2_adv;
    logic                s1_adv;
    logic                accept;
    logic                hs;
    logic [NREQ-1:0]     grant;
    logic [FLEN-1:0]     sel_dat;
    logic [TAG_W-1:0]    sel_tag;
    logic [SRC_W-1:0]    sel_src;
    logic [FCLASS_W-1:0] cls_mask;

    assign s2_adv    = !s2_v || resp_ready;
    assign s1_adv    = !s1_v || s2_adv;
    assign accept    = s1_adv;
    assign req_ready = grant & {NREQ{accept && !rst}};
    assign hs        = |req_ready;

    fclass_rr_arb #(
        .NREQ (NREQ)
    ) u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (req_valid),
        .adv   (hs),
        .grant (grant)
    );

    always_comb begin
        sel_dat = '0;
        sel_tag = '0;
        sel_src = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_dat = req_data[i*FLEN +: FLEN];
                sel_tag = req_tag[i*TAG_W +: TAG_W];
                sel_src = SRC_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v   <= 1'b0;
            s1_dat <= '0;
            s1_tag <= '0;
            s1_src <= '0;
        end else if (hs) begin
            s1_v   <= 1'b1;
            s1_dat <= sel_dat;
            s1_tag <= sel_tag;
            s1_src <= sel_src;
        end else if (s1_adv) begin
            s1_v   <= 1'b0;
        end
    end

    fclassifier u_cls (
        .operand (s1_dat),
        .mask    (cls_mask)
    );

    // S2 payload only moves when a new operand arrives, keeping resp_* stable in a stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_v    <= 1'b0;
            s2_mask <= '0;
            s2_tag  <= '0;
            s2_src  <= '0;
        end else if (s2_adv) begin
            s2_v <= s1_v;
            if (s1_v) begin
                s2_mask <= cls_mask;
                s2_tag  <= s1_tag;
                s2_src  <= s1_src;
            end
        end
    end

    assign resp_valid = s2_v;
    assign resp_data  = {{(XLEN-FCLASS_W){1'b0}}, s2_mask};
    assign resp_tag   = s2_tag;
    assign resp_src   = s2_src;

`ifdef FCLASS_SNAN_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            snan_cnt <= '0;
        else if (resp_valid && resp_ready && s2_mask[FCLASS_SNAN] && (snan_cnt != 16'hFFFF))
            snan_cnt <= snan_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_fclass_sched.sv
// Scoreboard bench for fclass_sched: random and directed operands vs. a behavioural model.
module tb_fclass_sched;
    import fclass_sched_pkg::*;

    localparam int NREQ  = 2;
    localparam int TAG_W = 5;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*FLEN-1:0]  req_data = '0;
    logic [NREQ*TAG_W-1:0] req_tag = '0;
    logic                  resp_valid;
    logic                  resp_ready = 1'b1;
    logic [XLEN-1:0]       resp_data;
    logic [TAG_W-1:0]      resp_tag;
    logic [0:0]            resp_src;
`ifdef FCLASS_SNAN_CNT_EN
    logic [15:0]           snan_cnt;
`endif

    fclass_sched #(
        .NREQ  (NREQ),
        .TAG_W (TAG_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data   (req_data),
        .req_tag    (req_tag),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_tag   (resp_tag),
        .resp_src   (resp_src)
`ifdef FCLASS_SNAN_CNT_EN
        ,
        .snan_cnt   (snan_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]      d;
        logic [TAG_W-1:0] t;
    } item_t;

    typedef struct {
        logic [31:0]      mask;
        logic [TAG_W-1:0] tag;
        int               src;
        int               acc;
    } exp_t;

    item_t src_q[NREQ][$];
    exp_t  sb_q[$];

    int checks   = 0;
    int passes   = 0;
    int cyc      = 0;
    int ptr_m    = 0;
    int vld_pct  = 100;
    int rdy_pct  = 100;
    int last_low = -10;
    int snan_m   = 0;

    logic [31:0]      prev_data = '0;
    logic [TAG_W-1:0] prev_tag  = '0;
    logic             prev_src  = 1'b0;
    logic             prev_stall = 1'b0;
    logic             prev_rst   = 1'b1;

    // Behavioural classification straight from the class table.
    function automatic logic [31:0] ref_class(input logic [31:0] x);
        int k;
        logic neg;
        neg = x[31];
        if (x[30:23] == 8'hFF) begin
            if (x[22:0] == 23'd0)       k = neg ? 9 : 2;
            else if (x[22])             k = 0;
            else                        k = 1;
        end else if (x[30:23] == 8'h00) begin
            if (x[22:0] == 23'd0)       k = neg ? 6 : 5;
            else                        k = neg ? 7 : 4;
        end else begin
            k = neg ? 8 : 3;
        end
        return 32'd1 << k;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp)
            passes++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Driver: present each requester's queue head, with optional random gaps.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (src_q[i].size() > 0 && $urandom_range(99) < vld_pct) begin
                req_valid[i]               = 1'b1;
                req_data[i*FLEN +: FLEN]   = src_q[i][0].d;
                req_tag[i*TAG_W +: TAG_W]  = src_q[i][0].t;
            end else begin
                req_valid[i]               = 1'b0;
                req_data[i*FLEN +: FLEN]   = $urandom;
            end
        end
        resp_ready = ($urandom_range(99) < rdy_pct);
    end

    // Monitor: pop the expected response whenever the DUT hands one off.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (prev_stall && !prev_rst) begin
                check("stall_valid", 64'(resp_valid), 64'd1);
                check("stall_data", 64'(resp_data), 64'(prev_data));
                check("stall_tag", 64'(resp_tag), 64'(prev_tag));
                check("stall_src", 64'(resp_src), 64'(prev_src));
            end
            if (resp_valid && resp_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_resp: got data 0x%0h, expected no response", resp_data);
                end else begin
                    e = sb_q.pop_front();
                    check("resp_data", 64'(resp_data), 64'(e.mask));
                    check("resp_tag", 64'(resp_tag), 64'(e.tag));
                    check("resp_src", 64'(resp_src), 64'(e.src));
                    if (last_low < e.acc + 1)
                        check("latency", 64'(cyc - e.acc), 64'd2);
                    else
                        check("latency_min", 64'(cyc - e.acc >= 2), 64'd1);
                    if (e.mask[1] && snan_m < 65535)
                        snan_m++;
                end
            end
        end
        if (!resp_ready)
            last_low = cyc;
        prev_stall = resp_valid && !resp_ready;
        prev_rst   = rst;
        prev_data  = resp_data;
        prev_tag   = resp_tag;
        prev_src   = resp_src;
    end

    // Scoreboard feed: predict the grant, compare req_ready, log accepted operands.
    always @(negedge clk) begin
        logic [NREQ-1:0] exp_g;
        int              idx;
        #1;
        idx   = -1;
        exp_g = '0;
        if (!rst && sb_q.size() < 2) begin
            for (int k = 0; k < NREQ; k++) begin
                int j;
                j = (ptr_m + k) % NREQ;
                if (idx < 0 && req_valid[j])
                    idx = j;
            end
        end
        if (idx >= 0)
            exp_g = {{(NREQ-1){1'b0}}, 1'b1} << idx;
        check("req_ready", 64'(req_ready), 64'(exp_g));
        if (rst) begin
            sb_q.delete();
            ptr_m = 0;
        end else if (idx >= 0) begin
            sb_q.push_back('{mask: ref_class(src_q[idx][0].d), tag: src_q[idx][0].t,
                             src: idx, acc: cyc});
            void'(src_q[idx].pop_front());
            ptr_m = (idx + 1) % NREQ;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic pulse_reset(input int n);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (n) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    function automatic logic [31:0] rand_operand();
        logic [31:0] pool [8];
        pool = '{32'h7FC00000, 32'h7F800001, 32'h00000000, 32'h80000000,
                 32'h7F800000, 32'hFF800000, 32'h00000001, 32'h80400000};
        if ($urandom_range(1) == 0)
            return pool[$urandom_range(7)];
        return $urandom;
    endfunction

    initial begin
        logic [31:0] sweep [5];
        int          w;
        sweep = '{32'h7FC00000, 32'h7F800001, 32'h00000000, 32'h3F800000, 32'h80000001};

        // Reset state, with requester 0 already waiting.
        src_q[0].push_back('{d: 32'hFF800000, t: 5'd3});
        repeat (2) @(negedge clk);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_data", 64'(resp_data), 64'd0);
        check("rst_resp_tag", 64'(resp_tag), 64'd0);
        check("rst_resp_src", 64'(resp_src), 64'd0);
`ifdef FCLASS_SNAN_CNT_EN
        check("rst_snan_cnt", 64'(snan_cnt), 64'd0);
`endif
        @(posedge clk);
        #1 rst = 1'b0;
        cycles(6);

        // Back-to-back class sweep on requester 1.
        for (int k = 0; k < 5; k++)
            src_q[1].push_back('{d: sweep[k], t: TAG_W'(10 + k)});
        cycles(10);

        // Both requesters pending straight out of reset: grants alternate.
        @(posedge clk);
        #1 rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            src_q[0].push_back('{d: rand_operand(), t: TAG_W'(k)});
            src_q[1].push_back('{d: rand_operand(), t: TAG_W'(16 + k)});
        end
        @(posedge clk);
        #1 rst = 1'b0;
        cycles(10);

        // Consumer stall with both requesters pending.
        rdy_pct = 0;
        for (int k = 0; k < 4; k++) begin
            src_q[0].push_back('{d: rand_operand(), t: TAG_W'(k + 4)});
            src_q[1].push_back('{d: rand_operand(), t: TAG_W'(k + 20)});
        end
        cycles(6);
        rdy_pct = 100;
        cycles(12);

        // Reset while both stages are full; the next request must still finish.
        rdy_pct = 0;
        for (int k = 0; k < 3; k++) begin
            src_q[0].push_back('{d: rand_operand(), t: TAG_W'(k + 8)});
            src_q[1].push_back('{d: rand_operand(), t: TAG_W'(k + 24)});
        end
        cycles(4);
        pulse_reset(1);
        @(negedge clk);
        check("post_rst_valid", 64'(resp_valid), 64'd0);
        check("post_rst_data", 64'(resp_data), 64'd0);
        rdy_pct = 100;
        cycles(12);

        // Randomised traffic with random gaps and stalls.
        vld_pct = 70;
        rdy_pct = 70;
        for (int c = 0; c < 300; c++) begin
            int r;
            r = $urandom_range(NREQ - 1);
            if (src_q[r].size() < 4 && $urandom_range(99) < 60)
                src_q[r].push_back('{d: rand_operand(), t: TAG_W'($urandom)});
            @(posedge clk);
        end

        // Drain everything that is still queued or in flight.
        vld_pct = 100;
        rdy_pct = 100;
        w = 0;
        while ((src_q[0].size() + src_q[1].size() + sb_q.size()) != 0 && w < 200) begin
            @(posedge clk);
            w++;
        end
        checks++;
        if ((src_q[0].size() + src_q[1].size() + sb_q.size()) != 0)
            $display("FAIL drain_timeout: %0d items outstanding, expected 0",
                     src_q[0].size() + src_q[1].size() + sb_q.size());
        else
            passes++;

`ifdef FCLASS_SNAN_CNT_EN
        @(negedge clk);
        check("snan_cnt", 64'(snan_cnt), 64'(snan_m));
`endif
        cycles(2);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
